// File: rtl/apb_protocol_checker.sv
// ----------------------------------------------------------------------------
// apb_protocol_checker
// Passive APB3/APB4 bus monitor. Tracks the transfer phase seen on the bus,
// flags protocol rule violations and keeps transfer statistics.
//
// Rule bits (viol_sticky):
//   [0] ABORT            transfer left SETUP/ACCESS without completing
//   [1] ENABLE_NO_SEL    penable=1 while psel=0
//   [2] ENABLE_NO_SETUP  access cycle with no preceding setup
//   [3] ADDR_CHANGE      paddr differs from the setup value
//   [4] WRITE_CHANGE     pwrite differs from the setup value
//   [5] WDATA_CHANGE     pwdata differs from the setup value (writes only)
//   [6] STRB_ERR         pstrb changed, or a read with nonzero strobes
//   [7] TIMEOUT          wait states reached TIMEOUT
//
// Ports:
//   pclk, preset                 clock, async active-high reset
//   psel/penable/pwrite/pready/pslverr, paddr, pwdata, pstrb   observed bus
//   clr                          synchronous clear of flags and counters
//   viol_sticky [7:0]            sticky per-rule flags
//   viol_pulse                   one cycle after any violation
//   viol_cnt/xfer_cnt/err_cnt    violation cycles / completed / errored xfers
//   max_wait                     largest wait count of a completed transfer
// ----------------------------------------------------------------------------
module apb_protocol_checker #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic                  clr,
    output logic [7:0]            viol_sticky,
    output logic                  viol_pulse,
    output logic [CNT_W-1:0]      viol_cnt,
    output logic [CNT_W-1:0]      xfer_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      max_wait
);

    localparam int STRB_W = DATA_W / 8;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    // Wait counter must be able to hold both TIMEOUT and the CNT_W range.
    localparam int WAIT_W = (CNT_W > TO_W) ? CNT_W : TO_W;
    localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        sat_inc_cnt = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        sat_inc_wait = (v == {WAIT_W{1'b1}}) ? v : v + WAIT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] clip_wait(input logic [WAIT_W-1:0] w);
        logic [WAIT_W-1:0] lim;
        lim = WAIT_W'({CNT_W{1'b1}});
        clip_wait = (w > lim) ? {CNT_W{1'b1}} : CNT_W'(w);
    endfunction

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_capture;
    logic                w_access;
    logic                w_complete;
    logic [7:0]          w_rules;
    logic                w_any;
    logic                w_setup_req;
    logic                w_access_req;
    logic [7:0]          w_sticky_base;
    logic [CNT_W-1:0]    w_vcnt_base;
    logic [CNT_W-1:0]    w_xcnt_base;
    logic [CNT_W-1:0]    w_ecnt_base;
    logic [CNT_W-1:0]    w_mwait_base;
    logic [CNT_W-1:0]    w_wait_clip;

    assign w_setup_req  = psel & ~penable;
    assign w_access_req = psel & penable;
    assign w_any        = |w_rules;

    // Phase tracking, rule evaluation and wait counting for the sampled cycle.
    always_comb begin
        w_phase_nxt = r_phase;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        w_complete  = 1'b0;
        w_wait_nxt  = '0;
        w_rules     = 8'h00;
        w_rules[1]  = penable & ~psel;
        case (r_phase)
            PH_IDLE: begin
                if (w_setup_req) begin
                    w_phase_nxt = PH_SETUP;
                    w_capture   = 1'b1;
                end else begin
                    w_phase_nxt = PH_IDLE;
                    w_rules[2]  = w_access_req;
                end
            end
            PH_SETUP, PH_ACCESS: begin
                if (w_access_req) begin
                    w_access = 1'b1;
                end else begin
                    w_rules[0] = 1'b1;
                    // A new setup may directly follow the aborted transfer.
                    if (w_setup_req) begin
                        w_phase_nxt = PH_SETUP;
                        w_capture   = 1'b1;
                    end else begin
                        w_phase_nxt = PH_IDLE;
                    end
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
            end
        endcase
        if (w_access) begin
            w_rules[3] = (paddr != r_addr);
            w_rules[4] = (pwrite != r_write);
            w_rules[5] = r_write & (pwdata != r_wdata);
            w_rules[6] = (pstrb != r_strb) | (~r_write & (r_strb != '0));
            if (pready) begin
                w_complete  = 1'b1;
                w_phase_nxt = PH_IDLE;
            end else begin
                w_phase_nxt = PH_ACCESS;
                w_wait_nxt  = sat_inc_wait(r_wait);
                // Fires only on the cycle the count first arrives at TIMEOUT.
                w_rules[7]  = (w_wait_nxt == TO_VAL) & (r_wait != TO_VAL);
            end
        end else begin
            w_complete = 1'b0;
        end
    end

    // Clear is applied before this cycle's events are merged in.
    always_comb begin
        w_sticky_base = clr ? 8'h00 : viol_sticky;
        w_vcnt_base   = clr ? '0 : viol_cnt;
        w_xcnt_base   = clr ? '0 : xfer_cnt;
        w_ecnt_base   = clr ? '0 : err_cnt;
        w_mwait_base  = clr ? '0 : max_wait;
        w_wait_clip   = clip_wait(r_wait);
    end

    // Phase, captured setup values and wait count.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_phase <= PH_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_wait  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_wait  <= w_wait_nxt;
            if (w_capture) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
        end
    end

    // Registered flag and statistics outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            viol_sticky <= 8'h00;
            viol_pulse  <= 1'b0;
            viol_cnt    <= '0;
            xfer_cnt    <= '0;
            err_cnt     <= '0;
            max_wait    <= '0;
        end else begin
            viol_sticky <= w_sticky_base | w_rules;
            viol_pulse  <= w_any;
            viol_cnt    <= w_any ? sat_inc_cnt(w_vcnt_base) : w_vcnt_base;
            xfer_cnt    <= w_complete ? w_xcnt_base + CNT_W'(1) : w_xcnt_base;
            err_cnt     <= (w_complete & pslverr) ? sat_inc_cnt(w_ecnt_base) : w_ecnt_base;
            max_wait    <= (w_complete && (w_wait_clip > w_mwait_base)) ? w_wait_clip : w_mwait_base;
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker (TIMEOUT=4, CNT_W=8).
module tb_apb_protocol_checker;

    logic        pclk;
    logic        preset;
    logic        psel, penable, pwrite, pready, pslverr, clr;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [7:0]  viol_sticky;
    logic        viol_pulse;
    logic [7:0]  viol_cnt, xfer_cnt, err_cnt, max_wait;

    int n_checks = 0;
    int n_fail   = 0;

    apb_protocol_checker #(
        .ADDR_W(8), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)
    ) dut (
        .pclk(pclk), .preset(preset),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .pready(pready), .pslverr(pslverr),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .clr(clr),
        .viol_sticky(viol_sticky), .viol_pulse(viol_pulse),
        .viol_cnt(viol_cnt), .xfer_cnt(xfer_cnt),
        .err_cnt(err_cnt), .max_wait(max_wait)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        sel, en, wr, rdy, err, clr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  e_sticky;
        logic        e_pulse;
        logic [7:0]  e_vcnt, e_xcnt, e_ecnt, e_mwait;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sel, en, wr, rdy, err, cl,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [7:0] st,
                                input logic pu, input logic [7:0] vc, xc, ec, mw);
        vec_t v;
        v.sel = sel; v.en = en; v.wr = wr; v.rdy = rdy; v.err = err; v.clr = cl;
        v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.e_sticky = st; v.e_pulse = pu; v.e_vcnt = vc;
        v.e_xcnt = xc; v.e_ecnt = ec; v.e_mwait = mw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] st, input logic pu,
                             input logic [7:0] vc, xc, ec, mw);
        check({tag, ".viol_sticky"}, 32'(viol_sticky), 32'(st));
        check({tag, ".viol_pulse"},  32'(viol_pulse),  32'(pu));
        check({tag, ".viol_cnt"},    32'(viol_cnt),    32'(vc));
        check({tag, ".xfer_cnt"},    32'(xfer_cnt),    32'(xc));
        check({tag, ".err_cnt"},     32'(err_cnt),     32'(ec));
        check({tag, ".max_wait"},    32'(max_wait),    32'(mw));
    endtask

    task automatic drive(input logic sel, en, wr, rdy, err, cl,
                         input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        psel = sel; penable = en; pwrite = wr; pready = rdy; pslverr = err; clr = cl;
        paddr = addr; pwdata = wdata; pstrb = strb;
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    int pulses;

    initial begin
        preset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        repeat (2) @(posedge pclk);
        #1;
        check_all("reset", 8'h00, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        preset = 1'b0;

        // sel en wr rdy err clr addr wdata strb | sticky pulse vcnt xcnt ecnt mwait
        // Clean write, 2 wait states.
        vecs.push_back(mk(1,0,1,0,0,0, 8'h10, 32'hA5A5A5A5, 4'hF, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,1,0,0,0, 8'h10, 32'hA5A5A5A5, 4'hF, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,1,0,0,0, 8'h10, 32'hA5A5A5A5, 4'hF, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,1,1,0,0, 8'h10, 32'hA5A5A5A5, 4'hF, 8'h00,0, 8'd0,8'd1,8'd0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h00,0, 8'd0,8'd1,8'd0,8'd2));
        // SETUP then psel dropped: abort.
        vecs.push_back(mk(1,0,1,0,0,0, 8'h20, 32'h0,        4'hF, 8'h00,0, 8'd0,8'd1,8'd0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h01,1, 8'd1,8'd1,8'd0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h01,0, 8'd1,8'd1,8'd0,8'd2));
        vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 32'h0,        4'h0, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        // Address changes 0x10 -> 0x14 while waiting; still completes.
        vecs.push_back(mk(1,0,1,0,0,0, 8'h10, 32'h11223344, 4'hF, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,1,0,0,0, 8'h14, 32'h11223344, 4'hF, 8'h08,1, 8'd1,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,1,1,0,0, 8'h14, 32'h11223344, 4'hF, 8'h08,1, 8'd2,8'd1,8'd0,8'd1));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h08,0, 8'd2,8'd1,8'd0,8'd1));
        vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 32'h0,        4'h0, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        // Read with strobes 0x3 and pslverr.
        vecs.push_back(mk(1,0,0,0,0,0, 8'h30, 32'h0,        4'h3, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,0,1,1,0, 8'h30, 32'h0,        4'h3, 8'h40,1, 8'd1,8'd1,8'd1,8'd0));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h40,0, 8'd1,8'd1,8'd1,8'd0));
        vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 32'h0,        4'h0, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        // Enable without setup, then enable without select.
        vecs.push_back(mk(1,1,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h04,1, 8'd1,8'd0,8'd0,8'd0));
        vecs.push_back(mk(0,1,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h06,1, 8'd2,8'd0,8'd0,8'd0));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h06,0, 8'd2,8'd0,8'd0,8'd0));
        // clr with a simultaneous violation: cleared first, then counted.
        vecs.push_back(mk(0,1,0,0,0,1, 8'h00, 32'h0,        4'h0, 8'h02,1, 8'd1,8'd0,8'd0,8'd0));
        vecs.push_back(mk(0,0,0,0,0,1, 8'h00, 32'h0,        4'h0, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        // pwrite, pwdata and pstrb all change in one access: one count, three flags.
        vecs.push_back(mk(1,0,1,0,0,0, 8'h40, 32'hDEADBEEF, 4'hF, 8'h00,0, 8'd0,8'd0,8'd0,8'd0));
        vecs.push_back(mk(1,1,0,1,0,0, 8'h40, 32'h00000000, 4'h1, 8'h70,1, 8'd1,8'd1,8'd0,8'd0));
        vecs.push_back(mk(0,0,0,0,0,0, 8'h00, 32'h0,        4'h0, 8'h70,0, 8'd1,8'd1,8'd0,8'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].en, vecs[i].wr, vecs[i].rdy, vecs[i].err,
                  vecs[i].clr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_sticky, vecs[i].e_pulse,
                      vecs[i].e_vcnt, vecs[i].e_xcnt, vecs[i].e_ecnt, vecs[i].e_mwait);
        end

        // Timeout: 10 wait states with TIMEOUT=4, then ready.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 32'h0BADF00D, 4'hF);
        tick();
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h50, 32'h0BADF00D, 4'hF);
            tick();
            if (viol_pulse) pulses++;
            if (k == 3) check("timeout.pulse_at_4th_wait", 32'(viol_pulse), 32'd1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 32'h0BADF00D, 4'hF);
        tick();
        if (viol_pulse) pulses++;
        check("timeout.pulse_count", 32'(pulses), 32'd1);
        check_all("timeout", 8'h80, 1'b0, 8'd1, 8'd1, 8'd0, 8'd10);

        // Reset mid-ACCESS, then a clean transfer.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60, 32'h12345678, 4'hF);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60, 32'h12345678, 4'hF);
        tick();
        #2;
        preset = 1'b1;
        #1;
        check_all("async_reset", 8'h00, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge pclk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        preset = 1'b0;
        tick();
        check_all("post_reset_idle", 8'h00, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h70, 32'hCAFEBABE, 4'hF);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h70, 32'hCAFEBABE, 4'hF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check_all("post_reset_xfer", 8'h00, 1'b0, 8'd0, 8'd1, 8'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_protocol_checker.md
APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning paddr width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning pwdata/prdata width, a multiple of 8.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the number of ACCESS wait states (pready=0) after which a timeout is flagged, >=1.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning the width of every counter output.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port pclk, in, 1, clock; all sampling is on its rising edge.
REQ-007 The block SHALL have port preset, in, 1, asynchronous active-high reset.
REQ-008 The block SHALL have ports psel, penable, pwrite, pready and pslverr, each in, 1, the observed APB signals.
REQ-009 The block SHALL have port paddr, in, ADDR_W, observed address.
REQ-010 The block SHALL have port pwdata, in, DATA_W, observed write data.
REQ-011 The block SHALL have port pstrb, in, DATA_W/8, observed APB4 write strobes.
REQ-012 The block SHALL have port clr, in, 1, synchronous clear of flags and counters.
REQ-013 The block SHALL have port viol_sticky, out, 8, sticky per-rule violation flags.
REQ-014 The block SHALL have port viol_pulse, out, 1, high for the cycle after any violation is detected.
REQ-015 The block SHALL have ports viol_cnt, xfer_cnt and err_cnt, each out, CNT_W, meaning violations, completed transfers and completed transfers with pslverr=1.
REQ-016 The block SHALL have port max_wait, out, CNT_W, the largest wait-state count of any completed transfer.

Function
REQ-017 The block SHALL keep an internal phase register with states IDLE, SETUP and ACCESS, which holds the phase of the previous sampled cycle.
REQ-018 In IDLE: psel=1, penable=0 SHALL go to SETUP and capture paddr, pwrite, pwdata and pstrb.
REQ-019 In IDLE: psel=1, penable=1 SHALL set rule 2 (ENABLE_NO_SETUP), and the phase SHALL stay IDLE.
REQ-020 In any state, penable=1 with psel=0 SHALL set rule 1 (ENABLE_NO_SEL), and the phase SHALL go to IDLE.
REQ-021 In SETUP, psel=1 and penable=1 SHALL enter the access cycle, and all other input combinations SHALL set rule 0 (ABORT).
REQ-022 After a SETUP abort, the next phase SHALL be SETUP with a fresh capture if psel=1 and penable=0, otherwise IDLE.
REQ-023 In ACCESS, psel=0 or penable=0 SHALL set rule 0, and the next phase SHALL be determined as in REQ-022.
REQ-024 In every access cycle, paddr, pwrite, pstrb and pwdata (pwdata only when the captured pwrite=1) SHALL be compared with the captured values, and a mismatch SHALL set rule 3, 4, 6 or 5 respectively.
REQ-025 Rule 6 SHALL also be set when the captured pwrite=0 and the captured pstrb is nonzero.
REQ-026 In an access cycle with pready=1, the transfer SHALL complete: xfer_cnt increments, err_cnt increments if pslverr=1, max_wait updates, and the phase goes to IDLE.
REQ-027 The wait count SHALL equal the number of access cycles with pready=0; when it reaches TIMEOUT, rule 7 SHALL be set once per transfer and the block SHALL keep waiting.
REQ-028 Multiple rules set in one cycle SHALL each set their viol_sticky bit, while viol_cnt increments by exactly 1.
REQ-029 viol_cnt, err_cnt and max_wait SHALL saturate at all-ones, and xfer_cnt SHALL wrap.
REQ-030 A wait count that exceeds the CNT_W range SHALL saturate at all-ones.
REQ-031 When clr and events occur in the same cycle, clearing SHALL be applied first and the events second, so the result is a flag set and a count of 1.
REQ-032 clr SHALL NOT change the phase register or the captured values.
REQ-033 All outputs SHALL be registered, with latency of one cycle from the sampling edge.

Reset
REQ-034 preset=1 SHALL immediately force the phase to IDLE, all outputs to 0, the captured values to 0 and the wait count to 0.
REQ-035 A transfer in flight at reset SHALL be discarded and not counted.
REQ-036 After reset is released, the first sampled cycle SHALL use the IDLE rules.

Verification
REQ-037 Scenario: write to 0x10, data 0xA5A5A5A5, pstrb=0xF, 2 wait states, pslverr=0 -> xfer_cnt=1, max_wait=2, viol_sticky=0x00.
REQ-038 Scenario: SETUP followed by psel=0 -> viol_sticky[0]=1, viol_pulse high for 1 cycle, viol_cnt=1.
REQ-039 Scenario: paddr changes 0x10 to 0x14 during a wait state -> viol_sticky[3]=1, and the transfer still completes with xfer_cnt=1.
REQ-040 Scenario: TIMEOUT=4 and pready held 0 for 10 cycles, then 1 -> viol_sticky[7]=1, viol_cnt=1, max_wait=10.
REQ-041 Scenario: read with pstrb=0x3 and pslverr=1 -> viol_sticky[6]=1, err_cnt=1.
REQ-042 Scenario: preset pulsed mid-ACCESS, then a clean transfer -> all outputs 0 after reset, then xfer_cnt=1 and no violations.
